// File: rtl/uc_multiciclo.sv
// uc_multiciclo -- multi-cycle control unit for the processor core.
//
// Sequences every instruction through FETCH -> DECODE -> EXEC and back to
// FETCH. Loads and stores take an extra MEM phase with a request/ack
// handshake and a timeout. CALL/RET keep return addresses on a stack whose
// pointer lives here. HALT and every error park the unit in HLT until reset.
//
// Parameters
//   STACK_DEPTH  return-address entries (>= 1)
//   TIMEOUT      maximum MEM cycles spent waiting for mem_ack (>= 1)
//
// Ports
//   clk        in   clock, all state changes on the rising edge
//   reset_n    in   asynchronous active-low reset
//   Opcode     in   IR opcode field, valid from DECODE onward
//   zero       in   registered zero flag, sampled in EXEC only
//   mem_ack    in   data-memory completion pulse, honoured only in MEM
//   AluOp      out  ALU operation
//   s_inc      out  PC source: 1 = PC+1, 0 = jump target
//   s_ret      out  PC source override: stack top (sp-1)
//   s_inm      out  register-file write data from immediate
//   we, wez    out  register-file write enable, zero-flag write enable
//   pc_we      out  PC load
//   ir_we      out  IR load
//   push, pop  out  stack write at sp / stack read at sp-1
//   sp         out  stack pointer = number of valid entries
//   mem_req    out  data-memory request
//   mem_wr     out  1 = store, 0 = load
//   halted     out  unit is parked in HLT
//   stack_err  out  sticky: CALL on full stack or RET on empty stack
//   mem_err    out  sticky: memory access timed out
module uc_multiciclo #(
  parameter int  STACK_DEPTH = 8,
  parameter int  TIMEOUT     = 15,
  localparam int SP_W        = $clog2(STACK_DEPTH + 1),
  localparam int CNT_W       = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [5:0]      Opcode,
  input  logic            zero,
  input  logic            mem_ack,
  output logic [2:0]      AluOp,
  output logic            s_inc,
  output logic            s_ret,
  output logic            s_inm,
  output logic            we,
  output logic            wez,
  output logic            pc_we,
  output logic            ir_we,
  output logic            push,
  output logic            pop,
  output logic [SP_W-1:0] sp,
  output logic            mem_req,
  output logic            mem_wr,
  output logic            halted,
  output logic            stack_err,
  output logic            mem_err
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HLT    = 3'd4
  } state_t;

  localparam logic [SP_W-1:0]  SP_MAX   = SP_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_st;
  logic             stack_err_set;
  logic             mem_err_set;
  logic             jump_taken;

  // Jump condition from the low opcode bits; zero only matters in EXEC.
  always_comb begin
    jump_taken = 1'b0;
    case (Opcode[1:0])
      2'b00:   jump_taken = 1'b1;
      2'b01:   jump_taken = ~zero;
      2'b10:   jump_taken = zero;
      default: jump_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      sp        <= '0;
      wait_cnt  <= '0;
      mem_st    <= 1'b0;
      stack_err <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      state <= state_next;

      // push/pop are only issued when the bound check allows it, so sp
      // stays within 0..STACK_DEPTH.
      if (push) begin
        sp <= sp + SP_W'(1);
      end else if (pop) begin
        sp <= sp - SP_W'(1);
      end

      // Counter is held at zero outside MEM, so it starts from zero on
      // every MEM entry and counts elapsed MEM cycles.
      if (state == MEM) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end else begin
        wait_cnt <= '0;
      end

      // Remember load vs store for the whole MEM phase.
      if (state == EXEC) begin
        mem_st <= (Opcode[4:2] == 3'b010);
      end

      if (stack_err_set) begin
        stack_err <= 1'b1;
      end
      if (mem_err_set) begin
        mem_err <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next    = state;
    AluOp         = 3'b000;
    s_inc         = 1'b0;
    s_ret         = 1'b0;
    s_inm         = 1'b0;
    we            = 1'b0;
    wez           = 1'b0;
    pc_we         = 1'b0;
    ir_we         = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    mem_req       = 1'b0;
    mem_wr        = 1'b0;
    halted        = 1'b0;
    stack_err_set = 1'b0;
    mem_err_set   = 1'b0;

    case (state)
      FETCH: begin
        ir_we      = 1'b1;
        state_next = DECODE;
      end

      DECODE: begin
        state_next = EXEC;
      end

      EXEC: begin
        state_next = FETCH;
        pc_we      = 1'b1;
        s_inc      = 1'b1;
        if (!Opcode[5]) begin
          AluOp = Opcode[4:2];
          we    = 1'b1;
          wez   = 1'b1;
        end else begin
          case (Opcode[4:2])
            3'b000: begin
              s_inm = 1'b1;
              we    = 1'b1;
            end
            3'b001, 3'b010: begin
              // PC advances only when the memory access completes.
              pc_we      = 1'b0;
              state_next = MEM;
            end
            3'b011: begin
              // NOP: just advance the PC.
            end
            3'b100: begin
              if (jump_taken) begin
                s_inc = 1'b0;
              end
            end
            3'b101: begin
              if (sp < SP_MAX) begin
                push  = 1'b1;
                s_inc = 1'b0;
              end else begin
                pc_we         = 1'b0;
                stack_err_set = 1'b1;
                state_next    = HLT;
              end
            end
            3'b110: begin
              if (sp != '0) begin
                pop   = 1'b1;
                s_ret = 1'b1;
              end else begin
                pc_we         = 1'b0;
                stack_err_set = 1'b1;
                state_next    = HLT;
              end
            end
            default: begin
              pc_we      = 1'b0;
              state_next = HLT;
            end
          endcase
        end
      end

      MEM: begin
        mem_req = 1'b1;
        mem_wr  = mem_st;
        if (mem_ack) begin
          pc_we      = 1'b1;
          s_inc      = 1'b1;
          we         = ~mem_st;
          state_next = FETCH;
        end else if (wait_cnt == CNT_LAST) begin
          // Last allowed cycle passed without ack: give up, PC untouched.
          mem_err_set = 1'b1;
          state_next  = HLT;
        end
      end

      HLT: begin
        halted = 1'b1;
      end

      default: begin
        state_next = FETCH;
      end
    endcase
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// tb_uc_multiciclo -- directed bench for uc_multiciclo (STACK_DEPTH=2,
// TIMEOUT=4). A table of single instructions is walked through
// FETCH/DECODE/EXEC, followed by hand-written sequences for stack
// overflow/underflow, load with delayed ack, store timeout, reset in MEM
// and reset out of HLT.
module tb_uc_multiciclo;

  localparam int STACK_DEPTH = 2;
  localparam int TIMEOUT     = 4;
  localparam int SP_W        = $clog2(STACK_DEPTH + 1);

  // Bit positions inside the packed output word "outs".
  localparam logic [16:0] B_INC  = 17'h02000;
  localparam logic [16:0] B_RET  = 17'h01000;
  localparam logic [16:0] B_INM  = 17'h00800;
  localparam logic [16:0] B_WE   = 17'h00400;
  localparam logic [16:0] B_WEZ  = 17'h00200;
  localparam logic [16:0] B_PCWE = 17'h00100;
  localparam logic [16:0] B_IRWE = 17'h00080;
  localparam logic [16:0] B_PUSH = 17'h00040;
  localparam logic [16:0] B_POP  = 17'h00020;
  localparam logic [16:0] B_REQ  = 17'h00010;
  localparam logic [16:0] B_WR   = 17'h00008;
  localparam logic [16:0] B_HALT = 17'h00004;
  localparam logic [16:0] B_SERR = 17'h00002;
  localparam logic [16:0] B_MERR = 17'h00001;
  localparam logic [16:0] NO_INC = ~B_INC;

  localparam logic [5:0] OP_CALL = 6'b110100;
  localparam logic [5:0] OP_RET  = 6'b111000;
  localparam logic [5:0] OP_LD   = 6'b100100;
  localparam logic [5:0] OP_ST   = 6'b101000;
  localparam logic [5:0] OP_HALT = 6'b111100;
  localparam logic [5:0] OP_NOP  = 6'b101100;

  logic            clk     = 1'b0;
  logic            reset_n = 1'b0;
  logic [5:0]      Opcode  = 6'd0;
  logic            zero    = 1'b0;
  logic            mem_ack = 1'b0;
  logic [2:0]      AluOp;
  logic            s_inc, s_ret, s_inm, we, wez, pc_we, ir_we;
  logic            push, pop, mem_req, mem_wr, halted, stack_err, mem_err;
  logic [SP_W-1:0] sp;
  logic [16:0]     outs;

  int errors = 0;
  int checks = 0;

  uc_multiciclo #(
    .STACK_DEPTH(STACK_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .Opcode   (Opcode),
    .zero     (zero),
    .mem_ack  (mem_ack),
    .AluOp    (AluOp),
    .s_inc    (s_inc),
    .s_ret    (s_ret),
    .s_inm    (s_inm),
    .we       (we),
    .wez      (wez),
    .pc_we    (pc_we),
    .ir_we    (ir_we),
    .push     (push),
    .pop      (pop),
    .sp       (sp),
    .mem_req  (mem_req),
    .mem_wr   (mem_wr),
    .halted   (halted),
    .stack_err(stack_err),
    .mem_err  (mem_err)
  );

  assign outs = {AluOp, s_inc, s_ret, s_inm, we, wez, pc_we, ir_we,
                 push, pop, mem_req, mem_wr, halted, stack_err, mem_err};

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]      opc;
    logic            z;
    logic [16:0]     exp;
    logic [SP_W-1:0] sp;
  } vec_t;

  vec_t tbl [14];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a falling edge; asserts reset asynchronously, checks the
  // decoded reset state, releases at the next falling edge (FETCH cycle).
  task automatic reset_now(input string tag);
    #1 reset_n = 1'b0;
    #1;
    check({tag, " async outs"}, outs, B_IRWE);
    check({tag, " async sp"}, sp, 0);
    @(negedge clk);
    check({tag, " held outs"}, outs, B_IRWE);
    reset_n = 1'b1;
  endtask

  // From a FETCH falling edge: load opcode, check FETCH and DECODE, stop at
  // the EXEC falling edge.
  task automatic to_exec(input string tag, input logic [5:0] opc,
                         input logic z);
    Opcode = opc;
    zero   = z;
    check({tag, " fetch"}, outs, B_IRWE);
    tick();
    check({tag, " decode"}, outs, 0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{6'b000100, 1'b0, {3'b001, 14'b0} | B_INC | B_WE | B_WEZ | B_PCWE, 2'd0};
    tbl[1]  = '{6'b011100, 1'b1, {3'b111, 14'b0} | B_INC | B_WE | B_WEZ | B_PCWE, 2'd0};
    tbl[2]  = '{6'b100000, 1'b0, B_INC | B_INM | B_WE | B_PCWE, 2'd0};
    tbl[3]  = '{OP_NOP,    1'b0, B_INC | B_PCWE, 2'd0};
    tbl[4]  = '{6'b110000, 1'b1, B_PCWE, 2'd0};
    tbl[5]  = '{6'b110001, 1'b0, B_PCWE, 2'd0};
    tbl[6]  = '{6'b110001, 1'b1, B_INC | B_PCWE, 2'd0};
    tbl[7]  = '{6'b110010, 1'b1, B_PCWE, 2'd0};
    tbl[8]  = '{6'b110010, 1'b0, B_INC | B_PCWE, 2'd0};
    tbl[9]  = '{6'b110011, 1'b1, B_INC | B_PCWE, 2'd0};
    tbl[10] = '{OP_CALL,   1'b0, B_PUSH | B_PCWE, 2'd0};
    tbl[11] = '{OP_CALL,   1'b0, B_PUSH | B_PCWE, 2'd1};
    tbl[12] = '{OP_RET,    1'b0, B_POP | B_RET | B_INC | B_PCWE, 2'd2};
    tbl[13] = '{OP_RET,    1'b0, B_POP | B_RET | B_INC | B_PCWE, 2'd1};

    // Reset state while reset_n is held low, then release on a falling edge.
    @(negedge clk);
    check("reset outs", outs, B_IRWE);
    check("reset sp", sp, 0);
    reset_n = 1'b1;

    // Table: every instruction takes exactly three cycles back to FETCH.
    for (int i = 0; i < 14; i++) begin
      to_exec($sformatf("v%0d", i), tbl[i].opc, tbl[i].z);
      check($sformatf("v%0d exec", i), outs, tbl[i].exp);
      check($sformatf("v%0d sp", i), sp, tbl[i].sp);
      tick();
    end
    check("table end sp", sp, 0);

    // Stack overflow: third CALL with sp == STACK_DEPTH.
    to_exec("call1", OP_CALL, 1'b0);
    check("call1 exec", outs, B_PUSH | B_PCWE);
    tick();
    to_exec("call2", OP_CALL, 1'b0);
    check("call2 exec", outs, B_PUSH | B_PCWE);
    tick();
    check("full sp", sp, 2);
    to_exec("call3", OP_CALL, 1'b0);
    check("overflow exec", outs & NO_INC, 0);
    tick();
    check("overflow hlt", outs, B_HALT | B_SERR);
    check("overflow sp", sp, 2);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("overflow stays", outs, B_HALT | B_SERR);
    reset_now("rst1");

    // Stack underflow: RET right after reset.
    to_exec("ret0", OP_RET, 1'b0);
    check("underflow exec", outs & NO_INC, 0);
    tick();
    check("underflow hlt", outs, B_HALT | B_SERR);
    check("underflow sp", sp, 0);
    reset_now("rst2");

    // Load, ack in the third MEM cycle; a stray ack in FETCH is ignored.
    mem_ack = 1'b1;
    to_exec("ld", OP_LD, 1'b0);
    mem_ack = 1'b0;
    check("ld exec", outs & NO_INC, 0);
    tick();
    check("ld mem1", outs, B_REQ);
    tick();
    check("ld mem2", outs, B_REQ);
    tick();
    mem_ack = 1'b1;
    #1;
    check("ld ack", outs, B_REQ | B_PCWE | B_INC | B_WE);
    @(posedge clk);
    #1 mem_ack = 1'b0;
    @(negedge clk);
    check("ld back fetch", outs, B_IRWE);

    // Store that never gets an ack: TIMEOUT request cycles, then HLT.
    to_exec("st", OP_ST, 1'b0);
    check("st exec", outs & NO_INC, 0);
    tick();
    for (int k = 1; k <= TIMEOUT; k++) begin
      check($sformatf("st wait%0d", k), outs, B_REQ | B_WR);
      tick();
    end
    check("st timeout", outs, B_HALT | B_MERR);
    tick();
    check("st stays", outs, B_HALT | B_MERR);
    reset_now("rst3");

    // Reset in the middle of MEM drops the request at once.
    to_exec("ld2", OP_LD, 1'b0);
    tick();
    check("ld2 mem1", outs, B_REQ);
    reset_now("rst4");

    // HALT with a non-empty stack, then reset out of HLT.
    to_exec("call4", OP_CALL, 1'b0);
    tick();
    check("pre-halt sp", sp, 1);
    to_exec("halt", OP_HALT, 1'b0);
    check("halt exec", outs & NO_INC, 0);
    tick();
    check("halt hlt", outs, B_HALT);
    tick();
    check("halt stays", outs, B_HALT);
    check("halt sp", sp, 1);
    reset_now("rst5");

    // Normal operation resumes after reset.
    to_exec("nop", OP_NOP, 1'b0);
    check("nop exec", outs, B_INC | B_PCWE);
    tick();
    check("nop back fetch", outs, B_IRWE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
